// File: rtl/sha3_theta_pipe.sv
// rtl/sha3_theta_pipe.sv - SHA-3 theta step pipeline; optional ocount via SHA3_THETA_PIPE_PERF_CNT_EN
module sha3_theta_pipe #(
    parameter int LANE_W       = 64,
    parameter int EXTRA_STAGES = 0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [4:0][LANE_W-1:0] isa,
    input  logic [4:0][LANE_W-1:0] isb,
    input  logic [4:0][LANE_W-1:0] isc,
    input  logic [4:0][LANE_W-1:0] isd,
    input  logic [4:0][LANE_W-1:0] ise,
    input  logic                   ivalid,
    input  logic                   theta_en,
    output logic                   iready,
    output logic [4:0][LANE_W-1:0] osa,
    output logic [4:0][LANE_W-1:0] osb,
    output logic [4:0][LANE_W-1:0] osc,
    output logic [4:0][LANE_W-1:0] osd,
    output logic [4:0][LANE_W-1:0] ose,
    output logic                   ovalid,
    input  logic                   oready
`ifdef SHA3_THETA_PIPE_PERF_CNT_EN
    ,
    output logic [31:0]            ocount
`endif
);

    localparam int NSTG = 2 + EXTRA_STAGES;

    // State is indexed [y][x]: row y selects the port, x selects the lane within it
    typedef logic [4:0][4:0][LANE_W-1:0] state_t;
    typedef logic [4:0][LANE_W-1:0]      lanes_t;

    state_t              a_in;
    lanes_t              c_d;
    lanes_t              d_lane;
    state_t              ap_d;
    logic                advance;

    state_t              s1_state_q;
    lanes_t              s1_c_q;
    logic                s1_theta_q;
    logic                s1_valid_q;
    state_t              stg_data_q [1:NSTG-1];
    logic [NSTG-1:1]     stg_valid_q;

    assign a_in    = {ise, isd, isc, isb, isa};
    assign advance = !ovalid || oready;
    assign iready  = advance;

    always_comb begin
        c_d = '0;
        for (int x = 0; x < 5; x++) begin
            c_d[x] = a_in[0][x] ^ a_in[1][x] ^ a_in[2][x] ^ a_in[3][x] ^ a_in[4][x];
        end
    end

    always_comb begin
        d_lane = '0;
        ap_d   = '0;
        for (int x = 0; x < 5; x++) begin
            d_lane[x] = s1_c_q[(x + 4) % 5]
                      ^ {s1_c_q[(x + 1) % 5][LANE_W-2:0], s1_c_q[(x + 1) % 5][LANE_W-1]};
        end
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                ap_d[y][x] = s1_theta_q ? (s1_state_q[y][x] ^ d_lane[x]) : s1_state_q[y][x];
            end
        end
    end

    // Whole pipe moves in lockstep; invalid slots still shift so bubbles survive
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid_q  <= 1'b0;
            s1_state_q  <= '0;
            s1_c_q      <= '0;
            s1_theta_q  <= 1'b0;
            stg_valid_q <= '0;
            for (int i = 1; i < NSTG; i++) begin
                stg_data_q[i] <= '0;
            end
        end else if (advance) begin
            s1_valid_q <= ivalid;
            if (ivalid) begin
                s1_state_q <= a_in;
                s1_c_q     <= c_d;
                s1_theta_q <= theta_en;
            end
            stg_valid_q[1] <= s1_valid_q;
            if (s1_valid_q) begin
                stg_data_q[1] <= ap_d;
            end
            for (int i = 2; i < NSTG; i++) begin
                stg_valid_q[i] <= stg_valid_q[i-1];
                if (stg_valid_q[i-1]) begin
                    stg_data_q[i] <= stg_data_q[i-1];
                end
            end
        end
    end

    assign ovalid                    = stg_valid_q[NSTG-1];
    assign {ose, osd, osc, osb, osa} = stg_data_q[NSTG-1];

`ifdef SHA3_THETA_PIPE_PERF_CNT_EN
    logic [31:0] ocount_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ocount_q <= 32'd0;
        end else if (ovalid && oready) begin
            ocount_q <= ocount_q + 32'd1;
        end
    end

    assign ocount = ocount_q;
`endif

endmodule

// File: tb/tb_sha3_theta_pipe.sv
// tb/tb_sha3_theta_pipe.sv - directed bench for sha3_theta_pipe (64-bit, 8-bit and 4-stage instances)
module tb_sha3_theta_pipe;

    typedef logic [4:0][4:0][63:0] st64_t;
    typedef logic [4:0][4:0][7:0]  st8_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic  rstn;
    logic  oready;

    // main instance: LANE_W=64, EXTRA_STAGES=0
    st64_t st_in;
    logic  ivalid, theta_en, iready, ovalid;
    logic [4:0][63:0] osa, osb, osc, osd, ose;
    st64_t out64;
    assign out64 = {ose, osd, osc, osb, osa};

    // 8-bit lane instance
    st8_t  st8;
    logic  ivalid8, theta8, iready8, ovalid8;
    logic [4:0][7:0] osa8, osb8, osc8, osd8, ose8;
    st8_t  out8;
    assign out8 = {ose8, osd8, osc8, osb8, osa8};

    // 4-stage instance
    st64_t ste;
    logic  ivalide, thetae, ireadye, ovalide;
    logic [4:0][63:0] osae, osbe, osce, osde, osee;
    st64_t oute;
    assign oute = {osee, osde, osce, osbe, osae};

`ifdef SHA3_THETA_PIPE_PERF_CNT_EN
    logic [31:0] ocount, ocount8, ocounte;
`endif

    sha3_theta_pipe #(.LANE_W(64), .EXTRA_STAGES(0)) dut (
        .clk(clk), .rstn(rstn),
        .isa(st_in[0]), .isb(st_in[1]), .isc(st_in[2]), .isd(st_in[3]), .ise(st_in[4]),
        .ivalid(ivalid), .theta_en(theta_en), .iready(iready),
        .osa(osa), .osb(osb), .osc(osc), .osd(osd), .ose(ose),
        .ovalid(ovalid), .oready(oready)
`ifdef SHA3_THETA_PIPE_PERF_CNT_EN
        , .ocount(ocount)
`endif
    );

    sha3_theta_pipe #(.LANE_W(8), .EXTRA_STAGES(0)) dut8 (
        .clk(clk), .rstn(rstn),
        .isa(st8[0]), .isb(st8[1]), .isc(st8[2]), .isd(st8[3]), .ise(st8[4]),
        .ivalid(ivalid8), .theta_en(theta8), .iready(iready8),
        .osa(osa8), .osb(osb8), .osc(osc8), .osd(osd8), .ose(ose8),
        .ovalid(ovalid8), .oready(oready)
`ifdef SHA3_THETA_PIPE_PERF_CNT_EN
        , .ocount(ocount8)
`endif
    );

    sha3_theta_pipe #(.LANE_W(64), .EXTRA_STAGES(2)) dut_e (
        .clk(clk), .rstn(rstn),
        .isa(ste[0]), .isb(ste[1]), .isc(ste[2]), .isd(ste[3]), .ise(ste[4]),
        .ivalid(ivalide), .theta_en(thetae), .iready(ireadye),
        .osa(osae), .osb(osbe), .osc(osce), .osd(osde), .ose(osee),
        .ovalid(ovalide), .oready(oready)
`ifdef SHA3_THETA_PIPE_PERF_CNT_EN
        , .ocount(ocounte)
`endif
    );

    // Single set lane v at (x0,y0): D[x0+1]=v and D[x0-1]=rotl(v,1), other D are zero
    function automatic st64_t exp_single(input int x0, input int y0, input logic [63:0] v);
        st64_t r;
        r = '0;
        r[y0][x0] = v;
        for (int y = 0; y < 5; y++) begin
            r[y][(x0 + 1) % 5] ^= v;
            r[y][(x0 + 4) % 5] ^= {v[62:0], v[63]};
        end
        return r;
    endfunction

    function automatic st64_t one_lane(input int x0, input int y0, input logic [63:0] v);
        st64_t r;
        r = '0;
        r[y0][x0] = v;
        return r;
    endfunction

    task automatic test_reset();
        rstn = 1'b0; oready = 1'b1;
        ivalid = 1'b0; ivalid8 = 1'b0; ivalide = 1'b0;
        theta_en = 1'b0; theta8 = 1'b0; thetae = 1'b0;
        st_in = '0; st8 = '0; ste = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ovalid !== 1'b0) begin failures++; $display("FAIL reset_ovalid got=%b exp=0", ovalid); end
        checks++; if (out64 !== '0) begin failures++; $display("FAIL reset_out64 not zero"); end
        checks++; if (iready !== 1'b1) begin failures++; $display("FAIL reset_iready got=%b exp=1", iready); end
        checks++; if (ovalid8 !== 1'b0 || out8 !== '0) begin failures++; $display("FAIL reset_dut8 ovalid=%b", ovalid8); end
        checks++; if (ovalide !== 1'b0 || oute !== '0) begin failures++; $display("FAIL reset_dut_e ovalid=%b", ovalide); end
`ifdef SHA3_THETA_PIPE_PERF_CNT_EN
        checks++; if (ocount !== 32'd0) begin failures++; $display("FAIL reset_ocount got=%0d exp=0", ocount); end
`endif
        rstn = 1'b1;
        @(negedge clk); #1;
        checks++; if (iready !== 1'b1 || ovalid !== 1'b0) begin failures++; $display("FAIL post_reset iready=%b ovalid=%b exp 1/0", iready, ovalid); end
    endtask

    task automatic test_zero();
        @(negedge clk);
        st_in = '0; theta_en = 1'b1; ivalid = 1'b1;
        @(negedge clk);
        ivalid = 1'b0;
        #1;
        checks++; if (ovalid !== 1'b0) begin failures++; $display("FAIL zero_early ovalid=%b exp=0", ovalid); end
        @(negedge clk); #1;
        checks++; if (ovalid !== 1'b1 || out64 !== '0) begin failures++; $display("FAIL zero_result ovalid=%b exp=1 data=%h", ovalid, out64[0]); end
        @(negedge clk); #1;
        checks++; if (ovalid !== 1'b0) begin failures++; $display("FAIL zero_one_cycle ovalid=%b exp=0", ovalid); end
    endtask

    task automatic test_single_bit();
        int          xs [4] = '{0, 2, 0, 3};
        int          ys [4] = '{0, 3, 0, 1};
        logic [63:0] vs [4] = '{64'h1, 64'h1, 64'h8000_0000_0000_0000, 64'h00A5};
        st64_t       exp;
        for (int k = 0; k < 4; k++) begin
            exp = exp_single(xs[k], ys[k], vs[k]);
            @(negedge clk);
            st_in = one_lane(xs[k], ys[k], vs[k]); theta_en = 1'b1; ivalid = 1'b1;
            @(negedge clk);
            ivalid = 1'b0; theta_en = 1'b0;
            @(negedge clk); #1;
            checks++;
            if (ovalid !== 1'b1 || out64 !== exp) begin
                failures++;
                $display("FAIL single_bit[%0d] ovalid=%b got=%h exp=%h", k, ovalid, out64, exp);
            end
        end
    endtask

    task automatic test_lane8();
        st8_t exp;
        exp = '0;
        exp[0][0] = 8'h80;
        for (int y = 0; y < 5; y++) begin
            exp[y][1] ^= 8'h80;
            exp[y][4] ^= 8'h01;
        end
        @(negedge clk);
        st8 = '0; st8[0][0] = 8'h80; theta8 = 1'b1; ivalid8 = 1'b1;
        @(negedge clk);
        ivalid8 = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (ovalid8 !== 1'b1 || out8 !== exp) begin
            failures++;
            $display("FAIL lane8_wrap ovalid=%b got=%h exp=%h", ovalid8, out8, exp);
        end
    endtask

    task automatic test_passthrough();
        logic [31:0] cnt0;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                ste[y][x] = {$urandom, $urandom};
`ifdef SHA3_THETA_PIPE_PERF_CNT_EN
        cnt0 = ocounte;
`else
        cnt0 = 32'd0;
`endif
        @(negedge clk);
        thetae = 1'b0; ivalide = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            ivalide = 1'b0; thetae = 1'b1;
            #1;
            checks++; if (ovalide !== 1'b0) begin failures++; $display("FAIL pass_early cycle=%0d ovalid=%b exp=0", c, ovalide); end
        end
        @(negedge clk); #1;
        checks++;
        if (ovalide !== 1'b1 || oute !== ste) begin
            failures++;
            $display("FAIL pass_data ovalid=%b got=%h exp=%h", ovalide, oute[0], ste[0]);
        end
        @(negedge clk); #1;
        checks++; if (ovalide !== 1'b0) begin failures++; $display("FAIL pass_one_cycle ovalid=%b exp=0", ovalide); end
`ifdef SHA3_THETA_PIPE_PERF_CNT_EN
        checks++; if (ocounte !== cnt0 + 32'd1) begin failures++; $display("FAIL pass_ocount got=%0d exp=%0d", ocounte, cnt0 + 32'd1); end
`else
        cnt0 = cnt0;
`endif
        thetae = 1'b0;
    endtask

    task automatic test_back_to_back();
        st64_t vec [3];
        st64_t exp [3];
        int    sent, got, stall;
        bit    seen;
        vec[0] = one_lane(0, 0, 64'h1);                   exp[0] = exp_single(0, 0, 64'h1);
        vec[1] = one_lane(1, 2, 64'h4);                   exp[1] = exp_single(1, 2, 64'h4);
        vec[2] = one_lane(4, 4, 64'h8000_0000_0000_0000); exp[2] = exp_single(4, 4, 64'h8000_0000_0000_0000);
        sent = 0; got = 0; stall = 0; seen = 1'b0;
        theta_en = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (ovalid && !seen) begin
                seen  = 1'b1;
                stall = 5;
            end
            oready = (stall == 0);
            #1;
            if (stall > 0) begin
                checks++;
                if (ovalid !== 1'b1 || out64 !== exp[0] || iready !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_stall stall=%0d ovalid=%b iready=%b data=%h", stall, ovalid, iready, out64[0]);
                end
                stall--;
            end
            if (ovalid && oready) begin
                checks++;
                if (got > 2) begin
                    failures++;
                    $display("FAIL b2b_extra result index=%0d exp none", got);
                end else if (out64 !== exp[got]) begin
                    failures++;
                    $display("FAIL b2b_order[%0d] got=%h exp=%h", got, out64, exp[got]);
                end
                got++;
            end
            if (sent < 3) begin
                ivalid = 1'b1;
                st_in  = vec[sent];
                if (iready) sent++;
            end else begin
                ivalid = 1'b0;
            end
        end
        oready = 1'b1; ivalid = 1'b0;
        checks++; if (got !== 3 || sent !== 3 || !seen) begin failures++; $display("FAIL b2b_count got=%0d sent=%0d exp=3/3", got, sent); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        oready = 1'b1; theta_en = 1'b1;
        st_in = one_lane(2, 2, 64'h55); ivalid = 1'b1;
        @(negedge clk);
        st_in = one_lane(3, 0, 64'h77);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1; ivalid = 1'b0;
        #1;
        checks++;
        if (ovalid !== 1'b0 || out64 !== '0 || iready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_state ovalid=%b iready=%b data=%h exp 0/1/0", ovalid, iready, out64[0]);
        end
`ifdef SHA3_THETA_PIPE_PERF_CNT_EN
        checks++; if (ocount !== 32'd0) begin failures++; $display("FAIL midreset_ocount got=%0d exp=0", ocount); end
`endif
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++;
            if (ovalid !== 1'b0) begin
                failures++;
                $display("FAIL midreset_ghost cycle=%0d ovalid=%b exp=0", c, ovalid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_single_bit();
        test_lane8();
        test_passthrough();
        test_back_to_back();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
